// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the execute-stage ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by ADD, SUB, SLT and SLTU.
// cout_o is carry-out for add and borrow (a < b unsigned) for subtract.
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic             c_raw;

    // Subtract as a + ~b + 1; the raw carry is then the inverse of borrow.
    assign b_eff           = b_i ^ {WIDTH{sub_i}};
    assign {c_raw, sum_o}  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    assign cout_o          = c_raw ^ sub_i;
    assign ovf_o           = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// Registered 8-bit ALU for the execute stage: one-cycle latency, result and
// status flags captured on en, held otherwise; valid marks a fresh capture.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [2:0]       aluCtrl,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             neg,
    output logic             valid
);

    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_ovf;
    logic             as_sub;

    logic [WIDTH-1:0] out_d, out_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_q, neg_q, valid_q;

    // Only ADD adds; SUB and both compares subtract.
    assign as_sub = (aluCtrl != ALU_ADD);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i    (ina),
        .b_i    (inb),
        .sub_i  (as_sub),
        .sum_o  (as_sum),
        .cout_o (as_cout),
        .ovf_o  (as_ovf)
    );

    always_comb begin
        out_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (aluCtrl)
            ALU_AND:  out_d = ina & inb;
            ALU_OR:   out_d = ina | inb;
            ALU_XOR:  out_d = ina ^ inb;
            ALU_NOR:  out_d = ~(ina | inb);
            ALU_ADD, ALU_SUB: begin
                out_d   = as_sum;
                carry_d = as_cout;
                ovf_d   = as_ovf;
            end
            ALU_SLTU: out_d = {{(WIDTH-1){1'b0}}, as_cout};
            // Diff MSB alone is wrong when the subtract overflows.
            ALU_SLT:  out_d = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            default:  out_d = '0;
        endcase
    end

    // zero/neg are registered from the same value loaded into out_q so they
    // always agree with it, yet still read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                out_q   <= out_d;
                zero_q  <= (out_d == '0);
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                neg_q   <= out_d[WIDTH-1];
            end
        end
    end

    assign out   = out_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;
    assign neg   = neg_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed plan cases then random traffic
// against an integer-arithmetic reference model.
module tb_alu_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] ina = '0;
    logic [7:0] inb = '0;
    logic [2:0] aluCtrl = '0;
    logic [7:0] out;
    logic       zero, carry, ovf, neg, valid;

    int checks = 0;
    int failures = 0;

    // reference state
    int m_out = 0;
    int m_z = 0, m_c = 0, m_v = 0, m_n = 0, m_vld = 0;

    alu_core dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ina(ina), .inb(inb),
        .aluCtrl(aluCtrl), .out(out), .zero(zero), .carry(carry),
        .ovf(ovf), .neg(neg), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},   int'(out),   m_out);
        check({tag, ".zero"},  int'(zero),  m_z);
        check({tag, ".carry"}, int'(carry), m_c);
        check({tag, ".ovf"},   int'(ovf),   m_v);
        check({tag, ".neg"},   int'(neg),   m_n);
        check({tag, ".valid"}, int'(valid), m_vld);
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Reference: plain integer arithmetic from the opcode definitions.
    task automatic model(input int a, input int b, input int op, input int e);
        int r, c, v, sa, sb, t;
        sa = sgn(a); sb = sgn(b);
        r = 0; c = 0; v = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin t = a + b; r = t % 256; c = (t > 255); t = sa + sb; v = (t > 127 || t < -128); end
            3: r = a ^ b;
            4: r = 255 - (a | b);
            5: r = (a < b) ? 1 : 0;
            6: begin r = (a - b + 256) % 256; c = (a < b); t = sa - sb; v = (t > 127 || t < -128); end
            default: r = (sa < sb) ? 1 : 0;
        endcase
        m_vld = e;
        if (e != 0) begin
            m_out = r; m_c = c; m_v = v;
            m_z = (r == 0); m_n = (r >= 128);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_z = 0; m_c = 0; m_v = 0; m_n = 0; m_vld = 0;
    endtask

    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic e);
        @(negedge clk);
        ina = a; inb = b; aluCtrl = op; en = e;
        model(int'(a), int'(b), int'(op), int'(e));
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Asynchronous reset: checked before any rising edge.
        ina = 8'($urandom); inb = 8'($urandom); aluCtrl = 3'($urandom); en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("add_carry", 8'h23, 8'hFF, 3'b010, 1'b1);
        check("add_carry.const", int'(out), 'h22);
        step("add_ovf",   8'h7F, 8'h01, 3'b010, 1'b1);
        check("add_ovf.const", int'(out), 'h80);
        step("sub",       8'h44, 8'h18, 3'b110, 1'b1);
        step("sub_zero",  8'h55, 8'h55, 3'b110, 1'b1);
        step("sub_borrow",8'h10, 8'h20, 3'b110, 1'b1);
        check("sub_borrow.const", int'(out), 'hF0);
        step("and",       8'h23, 8'hDF, 3'b000, 1'b1);
        step("or",        8'h23, 8'hFA, 3'b001, 1'b1);
        step("xor",       8'hF0, 8'hFF, 3'b011, 1'b1);
        step("nor",       8'hF0, 8'h0F, 3'b100, 1'b1);
        step("slt_neg",   8'h80, 8'h01, 3'b111, 1'b1);
        check("slt_neg.const", int'(out), 1);
        step("sltu",      8'h80, 8'h01, 3'b101, 1'b1);
        step("slt_ovf",   8'h7F, 8'h80, 3'b111, 1'b1);
        check("slt_ovf.const", int'(out), 0);
        step("sub_ovf",   8'h80, 8'h01, 3'b110, 1'b1);

        // Hold: load, then three en=0 cycles with changing inputs.
        step("hold_load", 8'h7F, 8'h7F, 3'b010, 1'b1);
        for (int i = 0; i < 3; i++)
            step("hold", 8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("hold_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, boundary operands mixed in.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 5))
                0: a = 8'h80;
                1: b = 8'h7F;
                2: b = a;
                default: ;
            endcase
            step("rand", a, b, 3'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
